// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one full-subtractor cell (two half-subtractor
// stages plus an OR) with a registered borrow, framed by start/busy/done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [1:0]       state_dbg_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             hs1_diff, hs1_borrow;
    logic             hs2_diff, hs2_borrow;
    logic             cell_diff, cell_borrow;
    logic [WIDTH-1:0] d_shifted;

    // First half-subtractor: a - b; second: (a - b) - borrow_in.
    assign hs1_diff    = a_sh_q[0] ^ b_sh_q[0];
    assign hs1_borrow  = ~a_sh_q[0] & b_sh_q[0];
    assign hs2_diff    = hs1_diff ^ br_q;
    assign hs2_borrow  = ~hs1_diff & br_q;
    assign cell_diff   = hs2_diff;
    assign cell_borrow = hs1_borrow | hs2_borrow;

    // New bit enters at the MSB; written as a shift so WIDTH=1 needs no slice.
    assign d_shifted = (d_sh_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bo_d    = bo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                br_d   = cell_borrow;
                d_sh_d = d_shifted;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                // Result registers only move on the final bit, so the previous
                // answer stays visible for the whole operation.
                if (cnt_q == LAST) begin
                    diff_d  = d_shifted;
                    bo_d    = cell_borrow;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == SHIFT) || (state_q == DONE);
    assign done        = (state_q == DONE);
    assign diff        = diff_q;
    assign borrow_out  = bo_q;
    assign state_dbg_o = state_q;

endmodule
